// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the pipelined multiplier.
//   mul_op_e   : mulsel encodings (mul / mulh / mulhsu / mulhu)
//   mul_dec_t  : decoded operation controls
//   mul_decode : maps a 3-bit mulsel code onto mul_dec_t. Codes outside the
//                four operations decode as "not legal" and produce a zero result.
// -----------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [2:0] {
        MUL_OP_MUL    = 3'b001,
        MUL_OP_MULH   = 3'b010,
        MUL_OP_MULHSU = 3'b011,
        MUL_OP_MULHU  = 3'b100
    } mul_op_e;

    typedef struct packed {
        logic a_signed;  // sign-extend rs1 to XLEN+1 bits
        logic b_signed;  // sign-extend rs2 to XLEN+1 bits
        logic hi_sel;    // return the upper product half
        logic legal;     // one of the four defined operations
    } mul_dec_t;

    function automatic mul_dec_t mul_decode(input logic [2:0] sel);
        mul_dec_t d;
        d = '0;
        case (sel)
            MUL_OP_MUL:    d = '{a_signed: 1'b0, b_signed: 1'b0, hi_sel: 1'b0, legal: 1'b1};
            MUL_OP_MULH:   d = '{a_signed: 1'b1, b_signed: 1'b1, hi_sel: 1'b1, legal: 1'b1};
            MUL_OP_MULHSU: d = '{a_signed: 1'b1, b_signed: 1'b0, hi_sel: 1'b1, legal: 1'b1};
            MUL_OP_MULHU:  d = '{a_signed: 1'b0, b_signed: 1'b0, hi_sel: 1'b1, legal: 1'b1};
            default:       d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mul_stage.sv
// -----------------------------------------------------------------------------
// mul_stage
// One pipeline register of the multiplier: valid bit, product payload and the
// high-half select travel together.
//   clk, rst_n      : clock, asynchronous active-low reset (clears everything)
//   en              : load the incoming slot (low = hold)
//   clr             : drop the held slot's valid bit; wins over en
//   vld_in/hi_in/data_in : incoming slot
//   vld_q/hi_q/data_q    : registered slot
// -----------------------------------------------------------------------------
module mul_stage #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         vld_in,
    input  logic         hi_in,
    input  logic [W-1:0] data_in,
    output logic         vld_q,
    output logic         hi_q,
    output logic [W-1:0] data_q
);

    logic         vld_d;
    logic         hi_d;
    logic [W-1:0] data_d;

    always_comb begin
        vld_d  = vld_q;
        hi_d   = hi_q;
        data_d = data_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (en) begin
            vld_d  = vld_in;
            hi_d   = hi_in;
            data_d = data_in;
        end
    end

    // Payload is reset too so that res reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            hi_q   <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            hi_q   <= hi_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipelined_multiplier.sv
// -----------------------------------------------------------------------------
// pipelined_multiplier
// RISC-V M-extension style multiplier (mul/mulh/mulhsu/mulhu) with a
// STAGES-deep valid/ready pipeline. The product is formed combinationally in
// front of the first register; the remaining registers only carry it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operation handshake (in_ready = !stall)
//   mulsel, a, b        : operation select and operands
//   out_valid/out_ready : result handshake
//   res                 : result (zero for undefined mulsel codes)
//   flush               : only with MULT_FLUSH_EN defined; drops all in-flight
//                         work at the next edge and blocks acceptance that cycle
// Parameters: XLEN (32/64), STAGES (1..4).
// -----------------------------------------------------------------------------
module pipelined_multiplier
    import mul_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef MULT_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mulsel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res
);

    localparam int PW = 2 * XLEN;

    // XLEN+1-bit operand extension; sgn selects sign vs zero extension.
    function automatic logic signed [XLEN:0] ext_op(input logic [XLEN-1:0] v, input logic sgn);
        return $signed({sgn & v[XLEN-1], v});
    endfunction

    mul_dec_t                dec;
    logic signed [XLEN:0]    a_ext;
    logic signed [XLEN:0]    b_ext;
    logic signed [PW-1:0]    a_wide;
    logic signed [PW-1:0]    b_wide;
    logic signed [PW-1:0]    prod_p0;

    logic                    vld_p  [STAGES+1];
    logic                    hi_p   [STAGES+1];
    logic [PW-1:0]           data_p [STAGES+1];

    logic                    stall;
    logic                    stage_en;
    logic                    stage_clr;

    // Stage 0: decode, extend, multiply. Only the low 2*XLEN bits of the
    // (XLEN+1)x(XLEN+1) signed product are ever returned, and a 2*XLEN-bit
    // multiply of the sign-extended operands yields exactly those bits.
    always_comb begin
        dec     = mul_decode(mulsel);
        a_ext   = ext_op(a, dec.a_signed);
        b_ext   = ext_op(b, dec.b_signed);
        a_wide  = {{(PW-XLEN-1){a_ext[XLEN]}}, a_ext};
        b_wide  = {{(PW-XLEN-1){b_ext[XLEN]}}, b_ext};
        prod_p0 = a_wide * b_wide;
        if (!dec.legal) begin
            prod_p0 = '0;
        end
    end

    // The whole pipe freezes together when the output slot is held.
    assign stall    = vld_p[STAGES] && !out_ready;
    assign stage_en = !stall;

`ifdef MULT_FLUSH_EN
    assign stage_clr = flush;
    assign in_ready  = !stall && !flush;
`else
    assign stage_clr = 1'b0;
    assign in_ready  = !stall;
`endif

    assign vld_p[0]  = in_valid && in_ready;
    assign hi_p[0]   = dec.hi_sel;
    assign data_p[0] = prod_p0;

    // Stages 1..STAGES: pure registers
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        mul_stage #(
            .W (PW)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (stage_en),
            .clr     (stage_clr),
            .vld_in  (vld_p[g]),
            .hi_in   (hi_p[g]),
            .data_in (data_p[g]),
            .vld_q   (vld_p[g+1]),
            .hi_q    (hi_p[g+1]),
            .data_q  (data_p[g+1])
        );
    end

    // Output: half selection from the last register
    assign out_valid = vld_p[STAGES];
    assign res       = hi_p[STAGES] ? data_p[STAGES][PW-1:XLEN] : data_p[STAGES][XLEN-1:0];

endmodule
